// File: rtl/grf_d.sv
// D-stage general register file: 31 x 32-bit registers, two combinational read ports,
// one W-stage write port with optional same-cycle bypass, plus a write-back commit monitor.
module grf_d #(
   parameter bit          BYPASS  = 1'b1,
   parameter logic [31:0] GP_INIT = 32'h0000_1800,
   parameter logic [31:0] SP_INIT = 32'h0000_2ffc
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  RA1,
   input  logic [4:0]  RA2,
   output logic [31:0] RD1,
   output logic [31:0] RD2,
   input  logic [4:0]  RW,
   input  logic [31:0] DataW,
   input  logic        RegWrite,
   output logic [31:0] WB_Count,
   output logic [4:0]  WB_LastRW,
   output logic [31:0] WB_LastData,
   output logic        WB_Valid
);

   localparam int unsigned XLEN = 32;
   localparam int unsigned AW   = 5;
   localparam int unsigned NREG = 32;

   logic [XLEN-1:0] regs_q [1:NREG-1];
   logic [XLEN-1:0] regs_d [1:NREG-1];
   logic [XLEN-1:0] wb_count_q, wb_count_d;
   logic [AW-1:0]   wb_last_rw_q, wb_last_rw_d;
   logic [XLEN-1:0] wb_last_data_q, wb_last_data_d;
   logic            wb_valid_q, wb_valid_d;
   logic            commit_c;
   logic [XLEN-1:0] rd1_c, rd2_c;

   function automatic logic [XLEN-1:0] reset_val(input int unsigned idx);
      if (idx == 28) return GP_INIT;
      if (idx == 29) return SP_INIT;
      return '0;
   endfunction

   // $0 is never stored, so a write to it does not commit at all
   always_comb begin
      commit_c = RegWrite && (RW != '0);
   end

   always_comb begin
      for (int unsigned i = 1; i < NREG; i++) begin
         regs_d[i] = (commit_c && (RW == AW'(i))) ? DataW : regs_q[i];
      end
      wb_count_d     = wb_count_q;
      wb_last_rw_d   = wb_last_rw_q;
      wb_last_data_d = wb_last_data_q;
      wb_valid_d     = wb_valid_q;
      if (commit_c) begin
         wb_count_d     = wb_count_q + XLEN'(1);
         wb_last_rw_d   = RW;
         wb_last_data_d = DataW;
         wb_valid_d     = 1'b1;
      end
   end

   // Reset has priority over a simultaneous write
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int unsigned i = 1; i < NREG; i++) begin
            regs_q[i] <= reset_val(i);
         end
         wb_count_q     <= '0;
         wb_last_rw_q   <= '0;
         wb_last_data_q <= '0;
         wb_valid_q     <= 1'b0;
      end else begin
         for (int unsigned i = 1; i < NREG; i++) begin
            regs_q[i] <= regs_d[i];
         end
         wb_count_q     <= wb_count_d;
         wb_last_rw_q   <= wb_last_rw_d;
         wb_last_data_q <= wb_last_data_d;
         wb_valid_q     <= wb_valid_d;
      end
   end

   // Read ports: $0 hardwired, optional forwarding of the in-flight W write
   always_comb begin
      rd1_c = '0;
      rd2_c = '0;
      for (int unsigned i = 1; i < NREG; i++) begin
         if (RA1 == AW'(i)) rd1_c = regs_q[i];
         if (RA2 == AW'(i)) rd2_c = regs_q[i];
      end
      if (BYPASS && commit_c && (RW == RA1)) rd1_c = DataW;
      if (BYPASS && commit_c && (RW == RA2)) rd2_c = DataW;
   end

   assign RD1         = rd1_c;
   assign RD2         = rd2_c;
   assign WB_Count    = wb_count_q;
   assign WB_LastRW   = wb_last_rw_q;
   assign WB_LastData = wb_last_data_q;
   assign WB_Valid    = wb_valid_q;

endmodule

// File: tb/tb_grf_d.sv
// Self-checking bench for grf_d: bypassing and non-bypassing instances share stimulus;
// expected values come from a reference register model through a scoreboard queue.
module tb_grf_d;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  RA1, RA2, RW;
   logic [31:0] DataW;
   logic        RegWrite;
   logic [31:0] RD1, RD2, WB_Count, WB_LastData;
   logic [4:0]  WB_LastRW;
   logic        WB_Valid;
   logic [31:0] n_rd1, n_rd2, n_count, n_last_data;
   logic [4:0]  n_last_rw;
   logic        n_valid;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q [$];
   logic [31:0] e, obs;

   // reference model
   logic [31:0] m_regs [32];
   logic [31:0] m_count, m_last_data;
   logic [4:0]  m_last_rw;
   logic        m_valid;

   always #5 clk = ~clk;

   grf_d #(.BYPASS(1'b1)) dut (
      .clk(clk), .reset(reset), .RA1(RA1), .RA2(RA2), .RD1(RD1), .RD2(RD2),
      .RW(RW), .DataW(DataW), .RegWrite(RegWrite),
      .WB_Count(WB_Count), .WB_LastRW(WB_LastRW), .WB_LastData(WB_LastData), .WB_Valid(WB_Valid)
   );

   grf_d #(.BYPASS(1'b0)) dut_nb (
      .clk(clk), .reset(reset), .RA1(RA1), .RA2(RA2), .RD1(n_rd1), .RD2(n_rd2),
      .RW(RW), .DataW(DataW), .RegWrite(RegWrite),
      .WB_Count(n_count), .WB_LastRW(n_last_rw), .WB_LastData(n_last_data), .WB_Valid(n_valid)
   );

   always @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
         m_regs[28]  = 32'h0000_1800;
         m_regs[29]  = 32'h0000_2ffc;
         m_count     = 32'h0;
         m_last_rw   = 5'h0;
         m_last_data = 32'h0;
         m_valid     = 1'b0;
      end else if (RegWrite && RW != 5'h0) begin
         m_regs[RW]  = DataW;
         m_count     = m_count + 32'h1;
         m_last_rw   = RW;
         m_last_data = DataW;
         m_valid     = 1'b1;
      end
   end

   function automatic logic [31:0] exp_rd(input logic [4:0] ra, input bit byp);
      if (ra == 5'h0) return 32'h0;
      if (byp && RegWrite && RW == ra) return DataW;
      return m_regs[ra];
   endfunction

   task automatic drive(input logic rg, input logic [4:0] rw, input logic [31:0] dw,
                        input logic [4:0] a1, input logic [4:0] a2);
      @(negedge clk);
      RegWrite = rg; RW = rw; DataW = dw; RA1 = a1; RA2 = a2;
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      RegWrite = 1'b0; RW = 5'h0; DataW = 32'h0; RA1 = 5'h0; RA2 = 5'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      RA1 = 5'd28; RA2 = 5'd29;
      #1;
      exp_q.push_back(32'h0000_1800);
      exp_q.push_back(32'h0000_2ffc);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      e = exp_q.pop_front(); obs = RD1; total++;
      if (obs !== e) begin bad++; $display("FAIL rst_gp got=%h exp=%h", obs, e); end
      e = exp_q.pop_front(); obs = RD2; total++;
      if (obs !== e) begin bad++; $display("FAIL rst_sp got=%h exp=%h", obs, e); end
      e = exp_q.pop_front(); obs = WB_Count; total++;
      if (obs !== e) begin bad++; $display("FAIL rst_count got=%h exp=%h", obs, e); end
      e = exp_q.pop_front(); obs = 32'(WB_Valid); total++;
      if (obs !== e) begin bad++; $display("FAIL rst_valid got=%h exp=%h", obs, e); end
      RA1 = 5'd5;
      #1;
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      e = exp_q.pop_front(); obs = RD1; total++;
      if (obs !== e) begin bad++; $display("FAIL rst_r5 got=%h exp=%h", obs, e); end
      e = exp_q.pop_front(); obs = WB_LastData | 32'(WB_LastRW); total++;
      if (obs !== e) begin bad++; $display("FAIL rst_last got=%h exp=%h", obs, e); end
   endtask

   task automatic test_write_read;
      drive(1'b1, 5'd5, 32'hdead_beef, 5'd5, 5'd0);
      exp_q.push_back(32'hdead_beef);
      e = exp_q.pop_front(); obs = RD1; total++;
      if (obs !== e) begin bad++; $display("FAIL wr_bypass got=%h exp=%h", obs, e); end
      drive(1'b0, 5'd5, 32'h0, 5'd5, 5'd0);
      exp_q.push_back(exp_rd(5'd5, 1'b1));
      exp_q.push_back(m_count);
      exp_q.push_back(32'(m_last_rw));
      exp_q.push_back(32'(m_valid));
      e = exp_q.pop_front(); obs = RD1; total++;
      if (obs !== e) begin bad++; $display("FAIL wr_stored got=%h exp=%h", obs, e); end
      e = exp_q.pop_front(); obs = WB_Count; total++;
      if (obs !== e) begin bad++; $display("FAIL wr_count got=%h exp=%h", obs, e); end
      e = exp_q.pop_front(); obs = 32'(WB_LastRW); total++;
      if (obs !== e) begin bad++; $display("FAIL wr_lastrw got=%h exp=%h", obs, e); end
      e = exp_q.pop_front(); obs = 32'(WB_Valid); total++;
      if (obs !== e) begin bad++; $display("FAIL wr_valid got=%h exp=%h", obs, e); end
   endtask

   task automatic test_zero_reg;
      drive(1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      e = exp_q.pop_front(); obs = RD1; total++;
      if (obs !== e) begin bad++; $display("FAIL z_pre_rd1 got=%h exp=%h", obs, e); end
      e = exp_q.pop_front(); obs = RD2; total++;
      if (obs !== e) begin bad++; $display("FAIL z_pre_rd2 got=%h exp=%h", obs, e); end
      @(posedge clk); #1;
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h1);
      exp_q.push_back(32'd5);
      e = exp_q.pop_front(); obs = RD1 | RD2; total++;
      if (obs !== e) begin bad++; $display("FAIL z_post got=%h exp=%h", obs, e); end
      e = exp_q.pop_front(); obs = WB_Count; total++;
      if (obs !== e) begin bad++; $display("FAIL z_count got=%h exp=%h", obs, e); end
      e = exp_q.pop_front(); obs = 32'(WB_LastRW); total++;
      if (obs !== e) begin bad++; $display("FAIL z_lastrw got=%h exp=%h", obs, e); end
   endtask

   task automatic test_dual_port;
      drive(1'b1, 5'd31, 32'h0000_3008, 5'd31, 5'd31);
      exp_q.push_back(32'h0000_3008);
      exp_q.push_back(32'h0000_3008);
      e = exp_q.pop_front(); obs = RD1; total++;
      if (obs !== e) begin bad++; $display("FAIL dp1_rd1 got=%h exp=%h", obs, e); end
      e = exp_q.pop_front(); obs = RD2; total++;
      if (obs !== e) begin bad++; $display("FAIL dp1_rd2 got=%h exp=%h", obs, e); end
      drive(1'b1, 5'd31, 32'h1, 5'd31, 5'd31);
      exp_q.push_back(32'h1);
      exp_q.push_back(32'h1);
      e = exp_q.pop_front(); obs = RD1; total++;
      if (obs !== e) begin bad++; $display("FAIL dp2_rd1 got=%h exp=%h", obs, e); end
      e = exp_q.pop_front(); obs = RD2; total++;
      if (obs !== e) begin bad++; $display("FAIL dp2_rd2 got=%h exp=%h", obs, e); end
      drive(1'b0, 5'd0, 32'h0, 5'd31, 5'd31);
      exp_q.push_back(32'h1);
      exp_q.push_back(32'd3);
      e = exp_q.pop_front(); obs = RD1 & RD2; total++;
      if (obs !== e) begin bad++; $display("FAIL dp_stored got=%h exp=%h", obs, e); end
      e = exp_q.pop_front(); obs = WB_Count; total++;
      if (obs !== e) begin bad++; $display("FAIL dp_count got=%h exp=%h", obs, e); end
   endtask

   task automatic test_reset_priority;
      @(negedge clk);
      reset = 1'b0; RegWrite = 1'b1; RW = 5'd7; DataW = 32'hffff_ffff;
      @(negedge clk);
      reset = 1'b1; RegWrite = 1'b0; RA1 = 5'd7; RA2 = 5'd31;
      #1;
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      e = exp_q.pop_front(); obs = RD1; total++;
      if (obs !== e) begin bad++; $display("FAIL rp_r7 got=%h exp=%h", obs, e); end
      e = exp_q.pop_front(); obs = RD2; total++;
      if (obs !== e) begin bad++; $display("FAIL rp_r31 got=%h exp=%h", obs, e); end
      e = exp_q.pop_front(); obs = WB_Count; total++;
      if (obs !== e) begin bad++; $display("FAIL rp_count got=%h exp=%h", obs, e); end
      e = exp_q.pop_front(); obs = 32'(WB_Valid); total++;
      if (obs !== e) begin bad++; $display("FAIL rp_valid got=%h exp=%h", obs, e); end
      RA1 = 5'd28; RA2 = 5'd29;
      #1;
      exp_q.push_back(32'h0000_1800);
      exp_q.push_back(32'h0000_2ffc);
      e = exp_q.pop_front(); obs = RD1; total++;
      if (obs !== e) begin bad++; $display("FAIL rp_gp got=%h exp=%h", obs, e); end
      e = exp_q.pop_front(); obs = RD2; total++;
      if (obs !== e) begin bad++; $display("FAIL rp_sp got=%h exp=%h", obs, e); end
   endtask

   task automatic test_counter_nobypass;
      drive(1'b1, 5'd1, 32'h1111_0001, 5'd0, 5'd0);
      drive(1'b1, 5'd2, 32'h2222_0002, 5'd0, 5'd0);
      drive(1'b1, 5'd3, 32'h3333_0003, 5'd0, 5'd0);
      drive(1'b1, 5'd4, 32'ha5a5_5a5a, 5'd4, 5'd3);
      exp_q.push_back(32'd3);
      exp_q.push_back(32'h3333_0003);
      exp_q.push_back(exp_rd(5'd4, 1'b1));
      exp_q.push_back(exp_rd(5'd4, 1'b0));
      exp_q.push_back(exp_rd(5'd3, 1'b0));
      e = exp_q.pop_front(); obs = WB_Count; total++;
      if (obs !== e) begin bad++; $display("FAIL ct_count got=%h exp=%h", obs, e); end
      e = exp_q.pop_front(); obs = WB_LastData; total++;
      if (obs !== e) begin bad++; $display("FAIL ct_lastdata got=%h exp=%h", obs, e); end
      e = exp_q.pop_front(); obs = RD1; total++;
      if (obs !== e) begin bad++; $display("FAIL nb_byp_rd1 got=%h exp=%h", obs, e); end
      e = exp_q.pop_front(); obs = n_rd1; total++;
      if (obs !== e) begin bad++; $display("FAIL nb_old_rd1 got=%h exp=%h", obs, e); end
      e = exp_q.pop_front(); obs = n_rd2; total++;
      if (obs !== e) begin bad++; $display("FAIL nb_r3 got=%h exp=%h", obs, e); end
      drive(1'b0, 5'd0, 32'h0, 5'd4, 5'd4);
      exp_q.push_back(32'ha5a5_5a5a);
      exp_q.push_back(32'd4);
      e = exp_q.pop_front(); obs = n_rd1; total++;
      if (obs !== e) begin bad++; $display("FAIL nb_new_rd1 got=%h exp=%h", obs, e); end
      e = exp_q.pop_front(); obs = n_count; total++;
      if (obs !== e) begin bad++; $display("FAIL nb_count got=%h exp=%h", obs, e); end
   endtask

   task automatic test_back_to_back;
      logic [4:0] last_rw;
      last_rw = 5'd1;
      for (int i = 0; i < 40; i++) begin
         logic [4:0] a1, a2, rw;
         rw = 5'($urandom_range(0, 31));
         a1 = ($urandom_range(0, 1) == 0) ? rw : 5'($urandom_range(0, 31));
         a2 = ($urandom_range(0, 1) == 0) ? last_rw : 5'($urandom_range(0, 31));
         drive(($urandom_range(0, 3) != 0), rw, $urandom, a1, a2);
         if (RegWrite) last_rw = rw;
         exp_q.push_back(exp_rd(RA1, 1'b1));
         exp_q.push_back(exp_rd(RA2, 1'b1));
         exp_q.push_back(exp_rd(RA1, 1'b0));
         exp_q.push_back(exp_rd(RA2, 1'b0));
         exp_q.push_back(m_count);
         e = exp_q.pop_front(); obs = RD1; total++;
         if (obs !== e) begin bad++; $display("FAIL b2b_rd1[%0d] got=%h exp=%h", i, obs, e); end
         e = exp_q.pop_front(); obs = RD2; total++;
         if (obs !== e) begin bad++; $display("FAIL b2b_rd2[%0d] got=%h exp=%h", i, obs, e); end
         e = exp_q.pop_front(); obs = n_rd1; total++;
         if (obs !== e) begin bad++; $display("FAIL b2b_nb_rd1[%0d] got=%h exp=%h", i, obs, e); end
         e = exp_q.pop_front(); obs = n_rd2; total++;
         if (obs !== e) begin bad++; $display("FAIL b2b_nb_rd2[%0d] got=%h exp=%h", i, obs, e); end
         e = exp_q.pop_front(); obs = WB_Count; total++;
         if (obs !== e) begin bad++; $display("FAIL b2b_count[%0d] got=%h exp=%h", i, obs, e); end
      end
      drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      exp_q.push_back(m_last_data);
      exp_q.push_back(32'(m_last_rw));
      e = exp_q.pop_front(); obs = WB_LastData; total++;
      if (obs !== e) begin bad++; $display("FAIL b2b_lastdata got=%h exp=%h", obs, e); end
      e = exp_q.pop_front(); obs = 32'(WB_LastRW); total++;
      if (obs !== e) begin bad++; $display("FAIL b2b_lastrw got=%h exp=%h", obs, e); end
   endtask

   initial begin
      test_reset;
      test_write_read;
      test_zero_reg;
      test_dual_port;
      test_reset_priority;
      test_counter_nobypass;
      test_back_to_back;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
